// File: rtl/joint_block_sequencer_pkg.sv
// Shared constants for the joint block sequencer: FSM encoding, default
// sync word and lane width, and the saturating overrun helper.
package joint_block_sequencer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_EMIT    = 2'd3;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hAAAA;
  localparam int          LW_DEF        = 38;
  localparam logic [7:0]  OVR_SAT       = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == OVR_SAT) begin
      sat_inc8 = OVR_SAT;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/joint_block_sequencer_lane_mux.sv
// Registered NLANE:1 selection of one word pair from the snapshot; the
// output holds whenever load_i is low.
module joint_lane_mux
  import joint_block_sequencer_pkg::*;
#(
  parameter int NLANE = 4,
  parameter int LW    = LW_DEF,
  localparam int SW   = $clog2(NLANE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NLANE*LW-1:0] snap0_i,
  input  logic [NLANE*LW-1:0] snap1_i,
  input  logic [SW-1:0]       sel_i,
  input  logic                load_i,
  output logic [LW-1:0]       out0_o,
  output logic [LW-1:0]       out1_o
);

  logic [LW-1:0] out0_q, out0_d;
  logic [LW-1:0] out1_q, out1_d;

  // Pick the selected lane on load, otherwise hold the presented pair.
  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    if (load_i) begin
      out0_d = snap0_i[int'(sel_i) * LW +: LW];
      out1_d = snap1_i[int'(sel_i) * LW +: LW];
    end else begin
      out0_d = out0_q;
      out1_d = out1_q;
    end
  end

  // Output pair register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_q <= '0;
      out1_q <= '0;
    end else begin
      out0_q <= out0_d;
      out1_q <= out1_d;
    end
  end

  assign out0_o = out0_q;
  assign out1_o = out1_q;

endmodule

// File: rtl/joint_block_sequencer.sv
// Frame sequencer: waits for the sync header, snapshots all lane pairs,
// holds for HOLD_CYC cycles, then emits lanes in order under valid/ready.
module joint_block_sequencer
  import joint_block_sequencer_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          NLANE     = 4,
  parameter int          HOLD_CYC  = 1,
  parameter int          LW        = LW_DEF,
  localparam int         LANE_W    = $clog2(NLANE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         array_header,
  input  logic [NLANE*LW-1:0] array_in0,
  input  logic [NLANE*LW-1:0] array_in1,
  input  logic                out_ready,
  output logic [LW-1:0]       array_out0,
  output logic [LW-1:0]       array_out1,
  output logic                out_valid,
  output logic [LANE_W-1:0]   out_lane,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          overrun_cnt
);

  localparam logic [3:0]        HOLD_LOAD = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANE - 1);

  logic [1:0]          state_q, state_d;
  logic [3:0]          hold_q, hold_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          ovr_q, ovr_d;
  logic [NLANE*LW-1:0] snap0_q, snap0_d;
  logic [NLANE*LW-1:0] snap1_q, snap1_d;

  logic                hdr_match_s;
  logic                accept_s;
  logic                last_s;
  logic                mux_load_s;
  logic [LANE_W-1:0]   mux_sel_s;
  logic [LANE_W-1:0]   lane_inc_s;

  assign hdr_match_s = (array_header == SYNC_WORD);
  assign accept_s    = valid_q & out_ready;
  assign last_s      = (lane_q == LAST_LANE);
  assign lane_inc_s  = lane_q + LANE_W'(1);

  // Next-state logic for the frame FSM, lane counter and overrun counter.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    lane_d     = lane_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    snap0_d    = snap0_q;
    snap1_d    = snap1_q;
    mux_load_s = 1'b0;
    mux_sel_s  = lane_q;

    // Headers seen mid-frame are only counted, never acted upon.
    if (hdr_match_s && (state_q != ST_IDLE)) begin
      ovr_d = sat_inc8(ovr_q);
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (hdr_match_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        snap0_d = array_in0;
        snap1_d = array_in1;
        if (HOLD_CYC == 0) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_q == 4'd0) begin
          state_d = ST_EMIT;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      ST_EMIT: begin
        // The first EMIT cycle loads lane 0 into the output register.
        if (!valid_q) begin
          mux_load_s = 1'b1;
          mux_sel_s  = '0;
          lane_d     = '0;
          valid_d    = 1'b1;
        end else if (accept_s) begin
          if (last_s) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            lane_d     = lane_inc_s;
            mux_load_s = 1'b1;
            mux_sel_s  = lane_inc_s;
          end
        end else begin
          lane_d = lane_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Frame state, counters and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= 4'd0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 8'd0;
      snap0_q <= '0;
      snap1_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
    end
  end

  joint_lane_mux #(
    .NLANE (NLANE),
    .LW    (LW)
  ) u_lane_mux (
    .clk     (clk),
    .rst     (rst),
    .snap0_i (snap0_q),
    .snap1_i (snap1_q),
    .sel_i   (mux_sel_s),
    .load_i  (mux_load_s),
    .out0_o  (array_out0),
    .out1_o  (array_out1)
  );

  assign out_valid   = valid_q;
  assign out_lane    = lane_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_joint_block_sequencer.sv
// Scoreboard bench for joint_block_sequencer: a frame-level timeline model
// predicts status outputs and queues the expected lane words per frame.
module tb_joint_block_sequencer;

  localparam int          NL = 4;
  localparam int          LW = 38;
  localparam int          H  = 1;
  localparam logic [15:0] SW = 16'hAAAA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]      hdr, hdr0;
  logic [NL*LW-1:0] in0, in1;
  logic             rdy, rdy0;

  logic [LW-1:0] out0, out1, out0_z, out1_z;
  logic          valid, valid_z, busy, busy_z, done, done_z;
  logic [1:0]    lane, lane_z;
  logic [7:0]    ovr, ovr_z;

  joint_block_sequencer #(.SYNC_WORD(SW), .NLANE(NL), .HOLD_CYC(H), .LW(LW)) dut (
    .clk(clk), .rst(rst), .array_header(hdr), .array_in0(in0), .array_in1(in1),
    .out_ready(rdy), .array_out0(out0), .array_out1(out1), .out_valid(valid),
    .out_lane(lane), .busy(busy), .frame_done(done), .overrun_cnt(ovr));

  joint_block_sequencer #(.SYNC_WORD(SW), .NLANE(NL), .HOLD_CYC(0), .LW(LW)) dut0 (
    .clk(clk), .rst(rst), .array_header(hdr0), .array_in0(in0), .array_in1(in1),
    .out_ready(rdy0), .array_out0(out0_z), .array_out1(out1_z), .out_valid(valid_z),
    .out_lane(lane_z), .busy(busy_z), .frame_done(done_z), .overrun_cnt(ovr_z));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame timeline model: a frame starts on a header seen while idle, the
  // snapshot is the input one edge later, lane 0 is offered 2+H edges after
  // the header and each accepted lane advances until the last one.
  typedef struct { int lane; logic [LW-1:0] d0; logic [LW-1:0] d1; } exp_t;
  exp_t sbq[$];
  bit   m_active, m_valid, m_done;
  int   m_t, m_lane, m_ovr;

  always @(posedge clk or posedge rst) begin
    bit hit;
    if (rst) begin
      m_active = 1'b0; m_valid = 1'b0; m_done = 1'b0;
      m_t = 0; m_lane = 0; m_ovr = 0;
      sbq.delete();
    end else begin
      hit = (hdr == SW);
      m_done = 1'b0;
      if (!m_active) begin
        if (hit) begin
          m_active = 1'b1;
          m_t = 0;
        end
      end else begin
        if (hit && m_ovr < 255) m_ovr++;
        m_t++;
        if (m_t == 1) begin
          for (int k = 0; k < NL; k++) begin
            exp_t e;
            e.lane = k; e.d0 = in0[k*LW +: LW]; e.d1 = in1[k*LW +: LW];
            sbq.push_back(e);
          end
        end
        if (m_valid) begin
          if (rdy) begin
            if (m_lane == NL - 1) begin
              m_valid = 1'b0; m_active = 1'b0; m_done = 1'b1;
            end else begin
              m_lane++;
            end
          end
        end else if (m_t == 2 + H) begin
          m_valid = 1'b1;
          m_lane = 0;
        end
      end
    end
  end

  // Monitor: status against the model, offered words against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_active);
      check("out_valid", valid, m_valid);
      check("frame_done", done, m_done);
      check("overrun_cnt", ovr, m_ovr);
      if (valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got lane %0d with no expected word", lane);
        end else begin
          check("sb_lane", lane, sbq[0].lane);
          check("sb_out0", out0, sbq[0].d0);
          check("sb_out1", out1, sbq[0].d1);
          if (rdy) void'(sbq.pop_front());
        end
      end
    end
  end

  function automatic logic [NL*LW-1:0] pattern_lanes();
    logic [NL*LW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*LW +: LW] = {2'(k), 34'h0, 2'(k)};
    return r;
  endfunction

  function automatic logic [NL*LW-1:0] rand_lanes();
    logic [NL*LW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*LW +: LW] = 38'({$urandom(), $urandom()});
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hdr();
    hdr = SW;
    step();
    hdr = 16'h0000;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 200; n++) begin
      step();
      if (!m_active && sbq.size() == 0) break;
    end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for idle, queue=%0d", name, sbq.size());
    end
  endtask

  task automatic wait_lane(input int l);
    int n;
    for (n = 0; n < 50; n++) begin
      step();
      if (m_valid && m_lane == l) break;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL wait_lane%0d: timeout, got none expected lane offered", l);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_out0"}, out0, 64'd0);
    check({tag, "_out1"}, out1, 64'd0);
    check({tag, "_valid"}, valid, 64'd0);
    check({tag, "_lane"}, lane, 64'd0);
    check({tag, "_busy"}, busy, 64'd0);
    check({tag, "_done"}, done, 64'd0);
    check({tag, "_ovr"}, ovr, 64'd0);
  endtask

  logic [LW-1:0] z_lane0;

  initial begin
    hdr = 16'h0; hdr0 = 16'h0; in0 = '0; in1 = '0; rdy = 1'b1; rdy0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_check("rst");
    check("rst_z_valid", valid_z, 64'd0);
    check("rst_z_busy", busy_z, 64'd0);
    check("rst_z_ovr", ovr_z, 64'd0);
    rst = 1'b0;
    step();

    // Basic frame with the patterned lanes and explicit latency.
    in0 = pattern_lanes(); in1 = pattern_lanes();
    pulse_hdr();
    check("lat_busy_k", busy, 64'd1);
    step(); check("lat_valid_k1", valid, 64'd0);
    step(); check("lat_valid_k2", valid, 64'd0);
    step(); check("lat_valid_k3", valid, 64'd1);
    check("lat_lane_k3", lane, 64'd0);
    wait_idle("basic");

    // Stall five cycles on lane 1.
    in0 = rand_lanes(); in1 = rand_lanes();
    pulse_hdr();
    wait_lane(1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_lane", lane, 64'd1);
      check("stall_valid", valid, 64'd1);
    end
    rdy = 1'b1;
    wait_idle("stall");

    // Inputs driven to all-ones right after capture must not leak out.
    in0 = rand_lanes(); in1 = rand_lanes();
    pulse_hdr();
    step();
    for (int k = 0; k < NL; k++) begin
      in0[k*LW +: LW] = 38'h3F_FFFF_FFFF;
      in1[k*LW +: LW] = 38'h3F_FFFF_FFFF;
    end
    wait_idle("late_inputs");

    // Random headers, data and backpressure.
    for (int i = 0; i < 400; i++) begin
      hdr = ($urandom_range(0, 4) == 0) ? SW : 16'($urandom());
      rdy = ($urandom_range(0, 3) != 0);
      in0 = rand_lanes(); in1 = rand_lanes();
      step();
    end
    hdr = 16'h0; rdy = 1'b1;
    wait_idle("random");

    // Continuous header: back-to-back frames, overrun saturates.
    hdr = SW;
    for (int i = 0; i < 300; i++) begin
      in0 = rand_lanes(); in1 = rand_lanes();
      step();
    end
    hdr = 16'h0;
    wait_idle("continuous");
    check("ovr_saturated", ovr, 64'd255);

    // Asynchronous reset while lane 2 is offered.
    in0 = rand_lanes(); in1 = rand_lanes();
    pulse_hdr();
    wait_lane(2);
    #2;
    rst = 1'b1;
    #1;
    reset_check("abort");
    step();
    rst = 1'b0;
    repeat (3) step();
    check("abort_idle_busy", busy, 64'd0);
    in0 = rand_lanes(); in1 = rand_lanes();
    pulse_hdr();
    wait_idle("after_abort");

    // HOLD_CYC=0 instance: near-miss header ignored, then 2-edge latency.
    in0 = rand_lanes(); in1 = rand_lanes();
    z_lane0 = in0[LW-1:0];
    hdr0 = 16'hAAAB;
    for (int i = 0; i < 5; i++) begin
      step();
      check("z_nomatch_busy", busy_z, 64'd0);
      check("z_nomatch_valid", valid_z, 64'd0);
    end
    hdr0 = SW;
    step();
    hdr0 = 16'h0;
    check("z_busy_k", busy_z, 64'd1);
    check("z_valid_k", valid_z, 64'd0);
    step(); check("z_valid_k1", valid_z, 64'd0);
    step(); check("z_valid_k2", valid_z, 64'd1);
    check("z_lane_k2", lane_z, 64'd0);
    check("z_data_k2", out0_z, z_lane0);
    repeat (8) step();
    check("z_end_busy", busy_z, 64'd0);
    check("z_ovr", ovr_z, 64'd0);

    check("sb_drained", sbq.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
